// File: rtl/msb_dec_pkg.sv
// -----------------------------------------------------------------------------
// msb_dec_pkg
//   Shared constants and types for the MSb bit decoder (ms_bit_decode).
//   - WIDTH / IDX_W / DEPTH / ERR_CNT_W : default configuration
//   - IDX_NONE    : all-ones index meaning "no bit set" (encoder's -1)
//   - ERR_CNT_MAX : saturation value of the illegal-index counter
//   - entry_t     : one FIFO entry {mask, err} for the default configuration
//   Optional feature macro used by the top: MSB_DEC_THERMO_EN.
// -----------------------------------------------------------------------------
package msb_dec_pkg;

    localparam int WIDTH     = 8;
    localparam int IDX_W     = 4;
    localparam int DEPTH     = 2;
    localparam int ERR_CNT_W = 8;

    localparam logic [IDX_W-1:0]     IDX_NONE    = {IDX_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // Packing order used everywhere: mask in the upper bits, err in bit 0.
    typedef struct packed {
        logic [WIDTH-1:0] mask;
        logic             err;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage : msb_dec_pkg

// File: rtl/mask_fifo.sv
// -----------------------------------------------------------------------------
// mask_fifo
//   Small synchronous FIFO holding decoded mask entries.
//   Ports:
//     clk, rst          clock (rising edge), synchronous active-high reset
//     push, din         write request and data (ignored when full)
//     pop               read request (ignored when empty)
//     dout              data at the head (zero when empty)
//     full, empty       occupancy flags
//     count             number of stored entries, 0..DEPTH
//   Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
//   A push while full is dropped even if a pop happens in the same cycle;
//   the producer is expected to gate push with !full.
// -----------------------------------------------------------------------------
module mask_fifo
    import msb_dec_pkg::*;
#(
    parameter int DEPTH  = msb_dec_pkg::DEPTH,
    parameter int DATA_W = msb_dec_pkg::ENTRY_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push_ok;
    logic pop_ok;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : mask_fifo

// File: rtl/ms_bit_decode.sv
// -----------------------------------------------------------------------------
// ms_bit_decode
//   Inverse of the MSb priority encoder: turns a bit index back into a WIDTH-bit
//   mask, buffered in a DEPTH-entry output FIFO. Illegal indices (WIDTH up to
//   all-ones minus one) decode to a zero mask with the err flag set and bump a
//   saturating counter.
//   Ports:
//     clk, rst        clock (rising edge), synchronous active-high reset
//     in_valid/in_ready/in_idx    index input stream
//     out_valid/out_ready         decoded output stream
//     out_mask, out_err           FIFO head (zero when empty)
//     err_cnt                     saturating count of illegal indices accepted
//     err_cnt_clr                 synchronous clear of err_cnt (wins over increment)
//     thermo                      only with MSB_DEC_THERMO_EN: legal idx gives
//                                 bits idx..0 set instead of a single bit
//   Handshake: a transfer happens on a rising edge where valid & ready are both
//   high; valid must not depend on ready, and a presented item stays put until
//   it transfers. in_ready = FIFO not full, with no pass-through on a full FIFO
//   even when the head is popped in the same cycle.
//   Configuration macro: MSB_DEC_THERMO_EN (default: undefined, one-hot only).
// -----------------------------------------------------------------------------
module ms_bit_decode
    import msb_dec_pkg::*;
#(
    parameter int WIDTH     = msb_dec_pkg::WIDTH,
    parameter int IDX_W     = msb_dec_pkg::IDX_W,
    parameter int DEPTH     = msb_dec_pkg::DEPTH,
    parameter int ERR_CNT_W = msb_dec_pkg::ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     in_idx,
`ifdef MSB_DEC_THERMO_EN
    input  logic                 thermo,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mask,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_cnt_clr
);

    // Entries are packed {mask, err}, matching msb_dec_pkg::entry_t.
    localparam int ENTRY_W = WIDTH + 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0]     IDX_ALL_ONES = {IDX_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_SAT      = {ERR_CNT_W{1'b1}};

    logic               accept;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;

    logic [WIDTH-1:0]   dec_mask;
    logic               dec_err;
    logic               use_thermo;

    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Occupancy is fully described by full/empty here; count is kept on the
    // FIFO interface for external checkers and debug.
    logic fifo_count_unused;
    assign fifo_count_unused = ^fifo_count;

`ifdef MSB_DEC_THERMO_EN
    assign use_thermo = thermo;
`else
    assign use_thermo = 1'b0;
`endif

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Decode of the presented index. Legal indices give a one-hot (or
    // thermometer) mask; the "none" code gives zero; anything else is an error.
    always_comb begin
        dec_mask = '0;
        dec_err  = 1'b0;
        if (int'(in_idx) < WIDTH) begin
            if (use_thermo) begin
                dec_mask = {WIDTH{1'b1}} >> (WIDTH - 1 - int'(in_idx));
            end else begin
                dec_mask = WIDTH'(1) << in_idx;
            end
        end else if (in_idx != IDX_ALL_ONES) begin
            dec_err = 1'b1;
        end
    end

    assign fifo_din = {dec_mask, dec_err};

    mask_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FIFO returns zero when empty, so the head outputs are zero then too.
    assign out_mask = fifo_dout[ENTRY_W-1:1];
    assign out_err  = fifo_dout[0];

    // Clear wins over a same-cycle increment; increment stops at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (accept && dec_err && (err_cnt_q != CNT_SAT)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule : ms_bit_decode

// File: tb/tb_ms_bit_decode.sv
// -----------------------------------------------------------------------------
// tb_ms_bit_decode
//   Self-checking bench for ms_bit_decode. A queue-based model (exp_q) holds the
//   masks that must sit in the output buffer; every cycle the DUT outputs are
//   compared with it. Directed scenarios add literal expectations, then a
//   randomized phase exercises mixed handshakes, clears and resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ms_bit_decode;

  localparam int WIDTH     = 8;
  localparam int IDX_W     = 4;
  localparam int DEPTH     = 2;
  localparam int ERR_CNT_W = 8;
  localparam int W         = WIDTH + 1;   // model entry {err, mask}
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [IDX_W-1:0]     in_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_mask;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_cnt_clr;
  logic                 thermo_drv;
`ifdef MSB_DEC_THERMO_EN
  logic                 thermo;
  assign thermo = thermo_drv;
`endif

  ms_bit_decode dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_idx      (in_idx),
`ifdef MSB_DEC_THERMO_EN
    .thermo      (thermo),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mask    (out_mask),
    .out_err     (out_err),
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  int exp_err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What an index must decode to, straight from the rules.
  function automatic logic [W-1:0] model_decode(input int idx, input bit th);
    logic [WIDTH-1:0] m;
    logic             e;
    m = '0;
    e = 1'b0;
    if (idx < WIDTH) begin
      if (th) m = WIDTH'((1 << (idx + 1)) - 1);
      else    m = WIDTH'(1 << idx);
    end else if (idx != (1 << IDX_W) - 1) begin
      e = 1'b1;
    end
    return {e, m};
  endfunction

  task automatic compare_all();
    logic [W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("in_ready",  32'(in_ready),  32'(exp_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("out_mask",  32'(out_mask),  32'(head[WIDTH-1:0]));
    check("out_err",   32'(out_err),   32'(head[WIDTH]));
    check("err_cnt",   32'(err_cnt),   32'(exp_err_cnt));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, update model at the rising edge, compare
  // at the next falling edge.
  task automatic step(input bit v, input int idx, input bit ordy,
                      input bit clr, input bit r, input bit th);
    bit acc;
    bit pp;
    bit th_eff;
    logic [W-1:0] e;
    in_valid    = v;
    in_idx      = IDX_W'(idx);
    out_ready   = ordy;
    err_cnt_clr = clr;
    rst         = r;
    thermo_drv  = th;
`ifdef MSB_DEC_THERMO_EN
    th_eff = th;
`else
    th_eff = 1'b0;
`endif
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_err_cnt = 0;
    end else begin
      acc = v && (exp_q.size() < DEPTH);
      pp  = ordy && (exp_q.size() > 0);
      e   = model_decode(idx, th_eff);
      if (pp)  void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
      if (clr) exp_err_cnt = 0;
      else if (acc && e[WIDTH] && exp_err_cnt < CNT_MAX) exp_err_cnt++;
    end
    @(negedge clk);
    compare_all();
  endtask

  logic [7:0] sweep_lit [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; out_ready = 1'b0;
    err_cnt_clr = 1'b0; thermo_drv = 1'b0;
    @(negedge clk);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // 1. reset mid-stream with two entries queued
    step(1, 9, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    check("pre_rst_err_cnt", 32'(err_cnt),  32'd1);
    check("pre_rst_full",    32'(in_ready), 32'd0);
    step(1, 3, 0, 0, 1, 0);
    step(1, 3, 0, 0, 1, 0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_cnt",   32'(err_cnt),   32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);

    // 2. one-hot sweep, one cycle after each accept
    for (int i = 0; i < WIDTH; i++) begin
      step(1, i, 1, 0, 0, 0);
      check("sweep_mask",  32'(out_mask),  32'(sweep_lit[i]));
      check("sweep_valid", 32'(out_valid), 32'd1);
      check("sweep_err",   32'(out_err),   32'd0);
    end
    step(0, 0, 1, 0, 0, 0);

    // 3. "none" and illegal index
    step(1, 15, 1, 0, 0, 0);
    check("none_mask", 32'(out_mask), 32'h00);
    check("none_err",  32'(out_err),  32'd0);
    step(1, 9, 1, 0, 0, 0);
    check("ill_mask", 32'(out_mask), 32'h00);
    check("ill_err",  32'(out_err),  32'd1);
    check("ill_cnt",  32'(err_cnt),  32'd1);
    step(0, 0, 1, 0, 0, 0);

    // 4. backpressure
    step(1, 2, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0);
    check("bp_stall",  32'(in_ready), 32'd0);
    check("bp_head",   32'(out_mask), 32'h04);
    step(1, 6, 0, 0, 0, 0);
    check("bp_hold",   32'(out_mask), 32'h04);
    step(1, 6, 1, 0, 0, 0);
    check("bp_second", 32'(out_mask), 32'h20);
    step(1, 6, 1, 0, 0, 0);
    check("bp_third",  32'(out_mask), 32'h40);
    step(0, 0, 1, 0, 0, 0);
    check("bp_drain",  32'(out_valid), 32'd0);

    // 5. saturation and clear priority
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 257; i++) begin
      step(1, $urandom_range(8, 14), 1, 0, 0, 0);
    end
    check("sat_cnt", 32'(err_cnt), 32'd255);
    step(1, 10, 1, 1, 0, 0);
    check("clr_cnt", 32'(err_cnt), 32'd0);
    step(0, 0, 1, 0, 0, 0);

`ifdef MSB_DEC_THERMO_EN
    // 6. thermometer masks
    step(1, 3, 1, 0, 0, 1);
    check("thermo_3", 32'(out_mask), 32'h0F);
    step(1, 7, 1, 0, 0, 1);
    check("thermo_7", 32'(out_mask), 32'hFF);
    step(1, 0, 1, 0, 0, 1);
    check("thermo_0", 32'(out_mask), 32'h01);
    step(0, 0, 1, 0, 0, 0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 15),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ms_bit_decode
